modred_pipe: RTL

MODRED_PIPE -- requirements
Module: modred_pipe

---
 rtl/modred_pkg.sv | 23 ++
 rtl/modred_stage.sv | 68 ++++++
 rtl/modred_pipe.sv | 101 ++++++++++
 3 files changed

// File: rtl/modred_pkg.sv
// Shared widths and the stage-width helpers for the Montgomery reduction pipeline.
package modred_pkg;

  // Default modulus width and reduction word width.
  localparam int DATA_W = 64;
  localparam int W      = 16;

  // Width of a stage output, given the width of its input.
  // One word is shifted out, but the result never gets narrower than DATA_W.
  // One bit is added for the carry of the sum, so nothing is truncated.
  function automatic int next_w(input int curr, input int data_w, input int w);
    return (((curr - w) > data_w) ? (curr - w) : data_w) + 1;
  endfunction

  // Width of the input of stage idx. Stage 0 takes the full 2*data_w operand.
  function automatic int stage_w(input int idx, input int data_w, input int w);
    int c;
    c = 2 * data_w;
    for (int j = 0; j < idx; j++) c = next_w(c, data_w, w);
    return c;
  endfunction

endpackage

// File: rtl/modred_stage.sv
// One word-reduction step: y = qH*N + (x >> W) + cy, with N = -x[W-1:0] mod 2^W.
// The step takes two register cycles: the product first, then the sum.
module modred_stage #(
  parameter int CURR_W = 128,
  parameter int NEXT_W = 113,
  parameter int DATA_W = modred_pkg::DATA_W,
  parameter int W      = modred_pkg::W,
  parameter int TAG_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [DATA_W-W-1:0] qH,
  input  logic [CURR_W-1:0]   x,
  input  logic                v_in,
  input  logic [TAG_W-1:0]    tag_in,
  output logic [NEXT_W-1:0]   y,
  output logic                v_out,
  output logic [TAG_W-1:0]    tag_out
);

  logic [W-1:0] lo;
  logic [W-1:0] neg;
  logic         cy;

  // N is chosen so that L + N clears the low word. When L = 0, N = 0 and there is no carry.
  // Otherwise L + N = 2^W, and that carry goes into the next word.
  assign lo  = x[W-1:0];
  assign neg = -lo;
  assign cy  = |lo;

  (* use_dsp = "yes" *) logic [DATA_W-1:0] prod_q;
  logic [CURR_W-W-1:0] hi_q;
  logic                cy_q;
  logic                v_q;
  logic [TAG_W-1:0]    tag_q;

  // Cycle 1: register qH*N, the shifted operand and the carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
      hi_q   <= '0;
      cy_q   <= 1'b0;
      v_q    <= 1'b0;
      tag_q  <= '0;
    end else if (en) begin
      prod_q <= DATA_W'(qH) * DATA_W'(neg);
      hi_q   <= x[CURR_W-1:W];
      cy_q   <= cy;
      v_q    <= v_in;
      tag_q  <= tag_in;
    end
  end

  // Cycle 2: register the full-width sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y       <= '0;
      v_out   <= 1'b0;
      tag_out <= '0;
    end else if (en) begin
      y       <= NEXT_W'(prod_q) + NEXT_W'(hi_q) + NEXT_W'(cy_q);
      v_out   <= v_q;
      tag_out <= tag_q;
    end
  end

endmodule

// File: rtl/modred_pipe.sv
// Pipelined Montgomery reduction: C = T * R^-1 mod q, with q = qH*2^W + 1 and R = 2^(K*W).
// The pipeline has K two-cycle word stages, then a one-cycle final subtraction.
// All slots move together whenever the output slot is free or is being drained.
module modred_pipe #(
  parameter int DATA_W = modred_pkg::DATA_W,
  parameter int W      = modred_pkg::W,
  parameter int TAG_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-W-1:0] qH,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_t,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_c,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);
  import modred_pkg::*;

  localparam int K     = DATA_W / W;
  localparam int RW    = K * W;                    // R = 2**RW
  localparam int YW    = stage_w(K, DATA_W, W);    // width after the last word stage
  localparam int CNT_W = $clog2(2 * K + 2);        // enough for 2K+1 occupied slots

  logic               en;
  logic [K:0]         v;
  logic [K:0][TAG_W-1:0] tag;
  logic [RW-1:0]      q;
  logic [YW-1:0]      y_fin;
  logic [DATA_W-1:0]  c_next;
  logic               accept;
  logic               fire;
  logic [CNT_W-1:0]   inflight;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign q        = {qH, W'(1)};

  // A slot that is not filled with an accepted operand takes in a bubble.
  // in_ready equals en, so v_in = in_valid gives the same result as in_valid && in_ready.
  assign v[0]   = in_valid;
  assign tag[0] = in_tag;

  for (genvar i = 0; i < K; i++) begin : g_stage
    localparam int CW = stage_w(i, DATA_W, W);
    localparam int NW = stage_w(i + 1, DATA_W, W);
    logic [CW-1:0] x;
    logic [NW-1:0] y;

    if (i == 0) begin : g_first
      assign x = in_t;
    end else begin : g_next
      assign x = g_stage[i-1].y;
    end

    modred_stage #(
      .CURR_W(CW), .NEXT_W(NW), .DATA_W(DATA_W), .W(W), .TAG_W(TAG_W)
    ) u_stage (
      .clk(clk), .reset(reset), .en(en), .qH(qH),
      .x(x), .v_in(v[i]), .tag_in(tag[i]),
      .y(y), .v_out(v[i+1]), .tag_out(tag[i+1])
    );
  end

  assign y_fin = g_stage[K-1].y;

  // The result after K steps is below 2q, so one conditional subtract is enough.
  // An input equal to q gives 0.
  assign c_next = DATA_W'((y_fin >= YW'(q)) ? (y_fin - YW'(q)) : y_fin);

  // Output slot: the corrected result and its tag. The slot holds while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= v[K];
      out_c     <= c_next;
      out_tag   <= tag[K];
    end
  end

  // The occupancy count is the number of valid slots, output slot included.
  // busy is the OR of all slot valid bits, so it is high exactly when this count is non-zero.
  assign accept = in_valid && en;
  assign fire   = out_valid && out_ready;

  // Track operands between capture and delivery.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight <= '0;
    else       inflight <= inflight + CNT_W'(accept) - CNT_W'(fire);
  end

  assign busy = (inflight != '0);

endmodule
